// File: rtl/frame_scanout.sv
// frame_scanout: snapshots a DIM x DIM 1-bit picture on start and streams it
// in raster order, BEAT pixels per valid/ready transfer. The snapshot lets the
// producer keep drawing into 'picture' while the previous frame drains.
module frame_scanout #(
  parameter  int DIM  = 64,
  parameter  int BEAT = 8,
  localparam int CW   = $clog2(DIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM*DIM-1:0]   picture,
  output logic [BEAT-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_x,
  output logic [CW-1:0]        out_y,
  output logic                 out_sol,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 done
);

  // Last beat start column of a row, and the column step between beats.
  // When BEAT == DIM the step truncates to 0 but is never used, since every
  // beat is then the last of its row.
  localparam logic [CW-1:0] X_LAST = CW'(DIM - BEAT);
  localparam logic [CW-1:0] X_STEP = CW'(BEAT);
  localparam logic [CW-1:0] Y_LAST = CW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        x;
  logic [CW-1:0]        y;
  logic [DIM*DIM-1:0]   snap;
  logic [2*CW-1:0]      base;
  logic                 last_beat;

  assign last_beat = (x == X_LAST) && (y == Y_LAST);

  // Frame sequencer: capture on start, walk the beat counters on each
  // handshake, and pulse done for one cycle after the final beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      snap      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap      <= picture;
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            // Counters advance even on the final beat; the natural wrap
            // leaves them back at (0,0) for the next frame.
            if (x == X_LAST) begin
              x <= '0;
              y <= y + CW'(1);
            end else begin
              x <= x + X_STEP;
            end
            if (last_beat) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Beat presentation: pixel(x,y) lives at bit y*DIM + x, which for a
  // power-of-two DIM is just the concatenation {y, x}.
  always_comb begin
    base     = {y, x};
    out_x    = x;
    out_y    = y;
    out_data = out_valid ? snap[base +: BEAT] : '0;
    out_sol  = out_valid && (x == '0);
    out_eof  = out_valid && last_beat;
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: random and directed frames compared beat by beat
// against a raster-order model of the captured picture.
module tb_frame_scanout;

  localparam int DIM  = 64;
  localparam int BEAT = 8;
  localparam int CW   = $clog2(DIM);
  localparam int BPR  = DIM / BEAT;
  localparam int NB   = BPR * DIM;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [DIM*DIM-1:0]  picture;
  logic [BEAT-1:0]     out_data;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_x;
  logic [CW-1:0]       out_y;
  logic                out_sol;
  logic                out_eof;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;

  // Picture the model expects the frame in flight to show.
  logic [DIM*DIM-1:0] ref_pic;
  int beats, sols, eofs, done_at;
  bit finished;

  frame_scanout #(.DIM(DIM), .BEAT(BEAT)) dut (
    .clk(clk), .rst(rst), .start(start), .picture(picture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_sol(out_sol), .out_eof(out_eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pixels of the k-th beat of a raster scan of ref_pic.
  function automatic logic [BEAT-1:0] exp_data(input int k);
    int ex;
    int ey;
    logic [BEAT-1:0] d;
    ex = (k % BPR) * BEAT;
    ey = k / BPR;
    for (int i = 0; i < BEAT; i++) d[i] = ref_pic[ey*DIM + ex + i];
    return d;
  endfunction

  task automatic set_pixel(input int px, input int py);
    picture[py*DIM + px] = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consume one frame that was started at the previous edge. pct is the
  // out_ready probability; stall_k holds ready low 5 cycles at that beat;
  // poke_k pulses start at that beat and again during DONE; abort_k asserts
  // rst while that beat is presented.
  task automatic drain(input int pct, input int stall_k, input int poke_k,
                       input int abort_k);
    int k;
    int stall;
    bit pend;
    bit poked;
    int ex;
    int ey;
    logic [BEAT+2*CW+1:0] prev;
    k = 0; stall = 0; pend = 0; poked = 0; prev = '0;
    beats = 0; sols = 0; eofs = 0; finished = 0; done_at = -1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_beat_latency: out_valid=%b required 1", out_valid);
    end
    for (int c = 0; c < 4*NB + 100; c++) begin
      start = 1'b0;
      if (done === 1'b1) begin
        finished = 1;
        done_at  = c;
        if (poke_k >= 0) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        break;
      end
      if (out_valid === 1'b1) begin
        if (pend) begin
          n_checks++;
          if ({out_data, out_x, out_y, out_sol, out_eof} !== prev) begin
            n_fail++;
            $display("FAIL hold_stable: beat %0d got %h required %h", k,
                     {out_data, out_x, out_y, out_sol, out_eof}, prev);
          end
        end
        ex = (k % BPR) * BEAT;
        ey = k / BPR;
        n_checks++;
        if (out_x !== CW'(ex) || out_y !== CW'(ey) || ey >= DIM) begin
          n_fail++;
          $display("FAIL beat_coords: beat %0d got (%0d,%0d) required (%0d,%0d)",
                   k, out_x, out_y, ex, ey);
        end
        n_checks++;
        if (out_data !== exp_data(k)) begin
          n_fail++;
          $display("FAIL beat_data: beat %0d got %h required %h", k, out_data,
                   exp_data(k));
        end
        n_checks++;
        if (out_sol !== (ex == 0) || out_eof !== (k == NB - 1)) begin
          n_fail++;
          $display("FAIL beat_flags: beat %0d got sol=%b eof=%b required sol=%b eof=%b",
                   k, out_sol, out_eof, ex == 0, k == NB - 1);
        end
        if (k == abort_k) begin
          #2 rst = 1'b1;
          #1;
          n_checks++;
          if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: valid=%b busy=%b done=%b required 0 0 0",
                     out_valid, busy, done);
          end
          out_ready = 1'b0;
          tick();
          tick();
          rst = 1'b0;
          return;
        end
        if (k == stall_k && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = ($urandom_range(99) < pct);
        end
        if (k == poke_k && !poked) begin
          start = 1'b1;
          poked = 1;
        end
        if (out_ready) begin
          k++;
          beats++;
          if (out_sol) sols++;
          if (out_eof) eofs++;
          pend = 0;
        end else begin
          pend = 1;
          prev = {out_data, out_x, out_y, out_sol, out_eof};
        end
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_dropped: beat %0d out_valid=%b required 1 before done",
                 k, out_valid);
      end
      tick();
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL frame_timeout: beats=%0d required done after %0d", beats, NB);
    end
  endtask

  // Common end-of-frame checks: beat count, done pulse width, idle after.
  task automatic check_frame_end(input string name);
    n_checks++;
    if (beats !== NB || eofs !== 1 || sols !== DIM) begin
      n_fail++;
      $display("FAIL %s_counts: beats=%0d eof=%0d sol=%0d required %0d 1 %0d",
               name, beats, eofs, sols, NB, DIM);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_in_done: busy=%b required 1", name, busy);
    end
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: done=%b busy=%b valid=%b required 0 0 0",
               name, done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; picture = '0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_x !== '0 || out_y !== '0 || out_sol !== 1'b0 || out_eof !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b x=%0d y=%0d sol=%b eof=%b required all 0",
               out_valid, busy, done, out_x, out_y, out_sol, out_eof);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_hline();
    picture = '0;
    for (int i = 0; i <= 8; i++) set_pixel(i, 9);
    ref_pic = picture;
    n_checks++;
    if (exp_data(9*BPR) !== 8'hFF || exp_data(9*BPR + 1) !== 8'h01) begin
      n_fail++;
      $display("FAIL hline_model: got %h %h required ff 01",
               exp_data(9*BPR), exp_data(9*BPR + 1));
    end
    pulse_start();
    drain(100, -1, -1, -1);
    n_checks++;
    if (done_at !== NB) begin
      n_fail++;
      $display("FAIL hline_done_latency: done %0d cycles after first beat, required %0d",
               done_at, NB);
    end
    check_frame_end("hline");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    drain(100, 3*BPR + 2, -1, -1);
    check_frame_end("stall");
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    drain(60, -1, -1, -1);
    check_frame_end("random_ready");
  endtask

  task automatic test_snapshot();
    picture = '0;
    for (int i = 0; i < DIM; i++) set_pixel(i, i);
    ref_pic = picture;
    pulse_start();
    picture = '0;
    n_checks++;
    if (exp_data(0) !== 8'h01 || exp_data(9*BPR + 1) !== 8'h02) begin
      n_fail++;
      $display("FAIL snapshot_model: got %h %h required 01 02",
               exp_data(0), exp_data(9*BPR + 1));
    end
    drain(80, -1, -1, -1);
    check_frame_end("snapshot");
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    drain(90, -1, 100, -1);
    n_checks++;
    if (beats !== NB || !finished) begin
      n_fail++;
      $display("FAIL busy_start_beats: beats=%0d required %0d", beats, NB);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_start_no_restart: cycle %0d valid=%b done=%b busy=%b required 0 0 0",
                 c, out_valid, done, busy);
      end
      tick();
    end
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    n_checks++;
    if (out_valid !== 1'b1 || out_x !== '0 || out_y !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_done: valid=%b x=%0d y=%0d busy=%b required 1 0 0 1",
               out_valid, out_x, out_y, busy);
    end
    drain(100, -1, -1, -1);
    check_frame_end("restart");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    drain(100, -1, -1, 200);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: cycle %0d done=%b valid=%b required 0 0",
                 c, done, out_valid);
      end
      tick();
    end
    for (int i = 0; i < DIM*DIM; i++) picture[i] = 1'($urandom);
    ref_pic = picture;
    pulse_start();
    n_checks++;
    if (out_x !== '0 || out_y !== '0 || out_sol !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_fresh_start: x=%0d y=%0d sol=%b required 0 0 1",
               out_x, out_y, out_sol);
    end
    drain(75, -1, -1, -1);
    check_frame_end("after_abort");
  endtask

  initial begin
    test_reset();
    test_hline();
    test_backpressure();
    test_snapshot();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
